fp_div_seq_ctrl: RTL and testbench

//  Sequenced IEEE-754 divider: valid/ready front end, FSM, one-quotient-bit-per-cycle

---
 rtl/fp_div_seq_ctrl_if.sv | 26 ++
 rtl/fp_div_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fp_div_seq_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequenced floating-point divider.
// Producer side drives a/b with in_valid and takes c with out_ready.
// Divider side answers with in_ready, out_valid, c and busy.
interface fp_div_seq_ctrl_if #(
  parameter int N = 23,
  parameter int M = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N+M:0]   a;
  logic [N+M:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [N+M:0]   c;
  logic           busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/fp_div_seq_ctrl.sv
// Sequenced IEEE-754 divider, restoring mantissa divide at one quotient bit per cycle, truncating.
// Latency: result valid N+3 edges after accept (2 edges for special operands when enabled).
// Backpressure: c held while out_valid & !out_ready; in_ready low from accept to output handshake.
// Optional FP_DIV_SPECIAL_EN: zero/inf/NaN classification plus exponent overflow/underflow clamping.
module fp_div_seq_ctrl #(
  parameter int N = 23,
  parameter int M = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_div_seq_ctrl_if.slave bus
);
  localparam int W    = N + M + 1;
  localparam int CW   = $clog2(N + 2);
  localparam logic [M+1:0] BIAS_E = (M+2)'(2**(M-1) - 1);
  localparam logic [M+1:0] ONE_E  = (M+2)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              sign;
  logic [N:0]        mb;
  logic [N+1:0]      rem;
  logic [N+1:0]      q;
  logic signed [M+1:0] e;
  logic [W-1:0]      c_q;
  logic              out_valid_q;

  logic              accept;
  logic              rem_ge;
  logic [N+1:0]      rem_sub;
  logic [N+1:0]      rem_nxt;
  logic [N-1:0]      frac_n;
  logic signed [M+1:0] exp_n;
  logic [W-1:0]      norm_res;

  logic [M-1:0]      a_exp, b_exp;

  assign a_exp  = bus.a[N+M-1:N];
  assign b_exp  = bus.b[N+M-1:N];
  assign accept = bus.in_valid && (state == S_IDLE);

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;

`ifdef FP_DIV_SPECIAL_EN
  logic [N-1:0] a_frac, b_frac;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic spec_now;
  logic [W-1:0] spec_now_res;
  logic spec_vld;
  logic [W-1:0] spec_res;

  assign a_frac = bus.a[N-1:0];
  assign b_frac = bus.b[N-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  // Classify the incoming pair; NaN outcomes take priority over inf, inf over zero.
  always_comb begin
    logic s;
    s            = bus.a[N+M] ^ bus.b[N+M];
    spec_now     = 1'b1;
    spec_now_res = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_now_res = {1'b0, {M{1'b1}}, 1'b1, {(N-1){1'b0}}};
    else if ((b_zero && !a_zero) || a_inf)
      spec_now_res = {s, {M{1'b1}}, {N{1'b0}}};
    else if (a_zero || b_inf)
      spec_now_res = {s, {M{1'b0}}, {N{1'b0}}};
    else
      spec_now = 1'b0;
  end
`endif

  // One restoring-divide step: trial subtract, keep or restore, shift left.
  always_comb begin
    rem_ge  = (rem >= {1'b0, mb});
    rem_sub = rem - {1'b0, mb};
    rem_nxt = rem_ge ? (rem_sub << 1) : (rem << 1);
  end

  // Normalise the quotient (it lies in (0.5, 2)) and assemble the packed result.
  always_comb begin
    frac_n = q[N+1] ? q[N:1] : q[N-1:0];
    exp_n  = q[N+1] ? e : (e - ONE_E);
`ifdef FP_DIV_SPECIAL_EN
    if (spec_vld)
      norm_res = spec_res;
    else if (exp_n >= $signed({2'b00, {M{1'b1}}}))
      norm_res = {sign, {M{1'b1}}, {N{1'b0}}};
    else if (exp_n <= $signed((M+2)'(0)))
      norm_res = {sign, {M{1'b0}}, {N{1'b0}}};
    else
      norm_res = {sign, exp_n[M-1:0], frac_n};
`else
    norm_res = {sign, exp_n[M-1:0], frac_n};
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sign        <= 1'b0;
      mb          <= '0;
      rem         <= '0;
      q           <= '0;
      e           <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      spec_vld    <= 1'b0;
      spec_res    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign  <= bus.a[N+M] ^ bus.b[N+M];
            mb    <= {1'b1, bus.b[N-1:0]};
            rem   <= {1'b0, 1'b1, bus.a[N-1:0]};
            q     <= '0;
            e     <= {2'b00, a_exp} - {2'b00, b_exp} + BIAS_E;
            cnt   <= CW'(N + 1);
`ifdef FP_DIV_SPECIAL_EN
            spec_vld <= spec_now;
            spec_res <= spec_now_res;
            state    <= spec_now ? S_NORM : S_ITER;
`else
            state <= S_ITER;
`endif
          end
        end
        S_ITER: begin
          rem <= rem_nxt;
          q   <= {q[N:0], rem_ge};
          if (cnt == '0)
            state <= S_NORM;
          else
            cnt <= cnt - CW'(1);
        end
        S_NORM: begin
          c_q         <= norm_res;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq_ctrl.sv
// Bench for fp_div_seq_ctrl: directed operand table with a scoreboard of expected
// quotients and latencies, backpressure hold, and reset abort mid-divide.
module tb_fp_div_seq_ctrl;
  localparam int N = 23;
  localparam int M = 8;

  typedef struct {
    logic [31:0] c;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   n_acc    = 0;
  int   n_out    = 0;
  logic ov_prev  = 1'b0;
  logic rdy_prev = 1'b0;
  logic [31:0] c_prev = '0;
  exp_t sb[$];

  fp_div_seq_ctrl_if #(.N(N), .M(M)) bus ();

  fp_div_seq_ctrl #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Monitor: sampled on the falling edge, mid-cycle between input drive and the next active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev  = 1'b0;
      rdy_prev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc = cyc + 1;
        n_acc++;
      end
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
        else check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
      end
      if (bus.out_valid && ov_prev && !rdy_prev)
        check("c_stable", bus.c, c_prev);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() != 0) begin
          check("result", bus.c, sb[0].c);
          void'(sb.pop_front());
        end
      end
      ov_prev  = bus.out_valid;
      rdy_prev = bus.out_ready;
      c_prev   = bus.c;
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] exp_c, input int lat);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    sb.push_back('{c: exp_c, lat: lat});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_c"},         bus.c,              32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  logic [31:0] tab_a [6];
  logic [31:0] tab_b [6];
  logic [31:0] tab_c [6];

  initial begin
    int t;
    int acc_snap;
    tab_a = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3FC00000, 32'h00800000};
    tab_b = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h7F000000};
`ifdef FP_DIV_SPECIAL_EN
    tab_c = '{32'h40400000, 32'h3EAAAAAA, 32'hBF2AAAAA, 32'h3F800000, 32'h3FC00000, 32'h00000000};
`else
    tab_c = '{32'h40400000, 32'h3EAAAAAA, 32'hBF2AAAAA, 32'h3F800000, 32'h3FC00000, 32'h41000000};
`endif

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed operand table, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      send(tab_a[i], tab_b[i], tab_c[i], N + 3);
      drain();
    end

    // Consumer stalls 10 cycles; new requests in that window must be ignored.
    bus.out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000, N + 3);
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stall_out_valid_timeout", 32'(bus.out_valid), 32'd1);
    acc_snap = n_acc;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a        = 32'h3F800000;
      bus.b        = 32'h3F800000;
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready),  32'd0);
      check("stall_busy",     32'(bus.busy),      32'd1);
      check("stall_valid",    32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    check("stall_no_accept", 32'(n_acc), 32'(acc_snap));
    bus.out_ready = 1'b1;
    drain();

    // Reset while iterating aborts the divide; no result may appear.
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, N + 3);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    t = n_out;
    repeat (40) @(posedge clk);
    #1;
    check("midreset_no_result", 32'(n_out), 32'(t));
    send(32'h40C00000, 32'h40000000, 32'h40400000, N + 3);
    drain();

`ifdef FP_DIV_SPECIAL_EN
    send(32'h3F800000, 32'h00000000, 32'h7F800000, 2);
    drain();
    send(32'h00000000, 32'h00000000, 32'h7FC00000, 2);
    drain();
    send(32'h7F800000, 32'h7F800000, 32'h7FC00000, 2);
    drain();
    send(32'h80000000, 32'h3F800000, 32'h80000000, 2);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
